reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the CNN datapath: one write port, NRD registered read ports, and a hardware clear sequencer that zeroes storage after reset or on command. It holds kernel weights and partial sums between the control unit and the MAC array. It adds these over the earlier fixed three-port file:

- storage initialisation
- configurable read-port count
- write-to-read bypass
- address-range checking
- read-valid signalling

---
 rtl/reg_file_mp_if.sv | 27 ++
 rtl/reg_file_mp.sv | 126 ++++++++++++
 tb/tb_reg_file_mp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - control, write and multi-port read bus of the register file
interface reg_file_mp_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int NRD    = 3
) ();
   logic                    clr;
   logic                    busy;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic                    rd_en;
   logic [NRD*ADDR_W-1:0]   rd_addr;
   logic [NRD*DATA_W-1:0]   rd_data;
   logic                    rd_valid;
   logic                    addr_err;

   modport master (
      output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  busy, rd_data, rd_valid, addr_err
   );

   modport slave (
      input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output busy, rd_data, rd_valid, addr_err
   );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - register file with one write port, NRD registered read ports and a clear sweep
module reg_file_mp #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 15,
   parameter int DATA_W = 8,
   parameter int NRD    = 3,
   parameter int BYPASS = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   reg_file_mp_if.slave   bus
);

   typedef enum logic {CLEAR, IDLE} state_t;

   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t                  stateQ, stateD;
   logic [ADDR_W-1:0]       ptrQ, ptrD;
   logic [DATA_W-1:0]       mem [DEPTH];
   logic                    memWe;
   logic [ADDR_W-1:0]       memWaddr;
   logic [DATA_W-1:0]       memWdata;
   logic                    wrHit;
   logic                    rdAccept;
   logic                    errD;
   logic [ADDR_W-1:0]       rAddr;
   logic [NRD*DATA_W-1:0]   rdDataD, rdDataQ;
   logic                    rdValidQ;
   logic                    addrErrQ;

   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_X;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ   <= CLEAR;
         ptrQ     <= '0;
         rdDataQ  <= '0;
         rdValidQ <= 1'b0;
         addrErrQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         ptrQ     <= ptrD;
         if (rdAccept)
            rdDataQ <= rdDataD;
         rdValidQ <= rdAccept;
         addrErrQ <= errD;
      end
   end

   // Storage carries no reset; the sweep is what defines its contents.
   always_ff @(posedge clk) begin
      if (memWe)
         mem[memWaddr] <= memWdata;
   end

   always_comb begin
      stateD   = stateQ;
      ptrD     = ptrQ;
      memWe    = 1'b0;
      memWaddr = ptrQ;
      memWdata = '0;
      wrHit    = 1'b0;
      rdAccept = 1'b0;
      errD     = 1'b0;
      rAddr    = '0;
      rdDataD  = '0;

      case (stateQ)
         CLEAR: begin
            memWe = 1'b1;
            ptrD  = ptrQ + 1'b1;
            if (ptrQ == LAST) begin
               stateD = IDLE;
               ptrD   = '0;
            end
         end

         IDLE: begin
            // A clear request drops a same-cycle write but still services the read.
            if (bus.clr) begin
               stateD = CLEAR;
               ptrD   = '0;
            end else if (bus.wr_en) begin
               if (inRange(bus.wr_addr)) begin
                  memWe    = 1'b1;
                  memWaddr = bus.wr_addr;
                  memWdata = bus.wr_data;
                  wrHit    = 1'b1;
               end else begin
                  errD = 1'b1;
               end
            end

            if (bus.rd_en) begin
               rdAccept = 1'b1;
               for (int i = 0; i < NRD; i++) begin
                  rAddr = bus.rd_addr[i*ADDR_W +: ADDR_W];
                  if (!inRange(rAddr)) begin
                     errD = 1'b1;
                     rdDataD[i*DATA_W +: DATA_W] = '0;
                  end else if ((BYPASS != 0) && wrHit && (rAddr == bus.wr_addr)) begin
                     rdDataD[i*DATA_W +: DATA_W] = bus.wr_data;
                  end else begin
                     rdDataD[i*DATA_W +: DATA_W] = mem[rAddr];
                  end
               end
            end
         end

         default: begin
            stateD = CLEAR;
            ptrD   = '0;
         end
      endcase
   end

   assign bus.busy     = (stateQ == CLEAR);
   assign bus.rd_data  = rdDataQ;
   assign bus.rd_valid = rdValidQ;
   assign bus.addr_err = addrErrQ;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed bench driving a write-first and a read-old-data instance in lockstep
module tb_reg_file_mp;

   logic clk;
   logic rst_n;
   int   passCnt;
   int   totalCnt;

   reg_file_mp_if #(.ADDR_W(4), .DATA_W(8), .NRD(3)) bus1 ();
   reg_file_mp_if #(.ADDR_W(4), .DATA_W(8), .NRD(3)) bus0 ();

   reg_file_mp #(.ADDR_W(4), .DEPTH(15), .DATA_W(8), .NRD(3), .BYPASS(1)) dutByp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   reg_file_mp #(.ADDR_W(4), .DEPTH(15), .DATA_W(8), .NRD(3), .BYPASS(0)) dutNoByp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      if (obs === exp)
         passCnt++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic clr, input logic wrEn, input logic [3:0] wAddr,
                        input logic [7:0] wData, input logic rdEn, input logic [11:0] rAddr);
      bus1.clr = clr;   bus0.clr = clr;
      bus1.wr_en = wrEn; bus0.wr_en = wrEn;
      bus1.wr_addr = wAddr; bus0.wr_addr = wAddr;
      bus1.wr_data = wData; bus0.wr_data = wData;
      bus1.rd_en = rdEn; bus0.rd_en = rdEn;
      bus1.rd_addr = rAddr; bus0.rd_addr = rAddr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 12'd0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      drive(1'b0, 1'b1, a, d, 1'b0, 12'd0);
      tick();
      idle();
   endtask

   task automatic rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
      drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, {a2, a1, a0});
      tick();
      idle();
   endtask

   task automatic busyLen(input string tag, input int exp);
      int n;
      n = 0;
      while (bus1.busy && n < 100) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      int n;
      int vld;
      passCnt  = 0;
      totalCnt = 0;
      rst_n    = 1'b0;
      idle();
      repeat (3) tick();

      chk("rst_busy", 32'(bus1.busy), 32'd1);
      chk("rst_rd_valid", 32'(bus1.rd_valid), 32'd0);
      chk("rst_addr_err", 32'(bus1.addr_err), 32'd0);
      chk("rst_rd_data", 32'(bus1.rd_data), 32'h0);

      rst_n = 1'b1;
      busyLen("sweep_len", 15);
      chk("sweep_len_nobyp_busy", 32'(bus0.busy), 32'd0);

      rd(4'd0, 4'd7, 4'd14);
      chk("swept_data", 32'(bus1.rd_data), 32'h000000);
      chk("swept_valid", 32'(bus1.rd_valid), 32'd1);
      tick();
      chk("valid_one_cycle", 32'(bus1.rd_valid), 32'd0);

      wr(4'd3, 8'hA5);
      wr(4'd9, 8'h3C);
      wr(4'd14, 8'hFF);
      rd(4'd3, 4'd9, 4'd14);
      chk("wr_rd_data", 32'(bus1.rd_data), 32'hFF3CA5);
      chk("wr_rd_valid", 32'(bus1.rd_valid), 32'd1);
      chk("wr_rd_data_nobyp", 32'(bus0.rd_data), 32'hFF3CA5);
      tick();
      chk("hold_data", 32'(bus1.rd_data), 32'hFF3CA5);
      chk("hold_valid", 32'(bus1.rd_valid), 32'd0);

      // back-to-back reads keep rd_valid high
      drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, {4'd3, 4'd3, 4'd3});
      tick();
      drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, {4'd9, 4'd9, 4'd9});
      tick();
      chk("b2b_valid", 32'(bus1.rd_valid), 32'd1);
      chk("b2b_data", 32'(bus1.rd_data), 32'h3C3C3C);
      idle();

      wr(4'd4, 8'h44);
      wr(4'd5, 8'h11);
      drive(1'b0, 1'b1, 4'd5, 8'h22, 1'b1, {4'd4, 4'd5, 4'd5});
      tick();
      idle();
      chk("bypass_on", 32'(bus1.rd_data), 32'h442222);
      chk("bypass_off", 32'(bus0.rd_data), 32'h441111);
      rd(4'd5, 4'd5, 4'd5);
      chk("post_bypass_on", 32'(bus1.rd_data), 32'h222222);
      chk("post_bypass_off", 32'(bus0.rd_data), 32'h222222);

      wr(4'd0, 8'h5A);
      wr(4'd2, 8'hC3);
      chk("no_err_inrange", 32'(bus1.addr_err), 32'd0);
      wr(4'd15, 8'h77);
      chk("wr_range_err", 32'(bus1.addr_err), 32'd1);
      tick();
      chk("wr_range_err_pulse", 32'(bus1.addr_err), 32'd0);
      rd(4'd15, 4'd0, 4'd2);
      chk("rd_range_data", 32'(bus1.rd_data), 32'hC35A00);
      chk("rd_range_err", 32'(bus1.addr_err), 32'd1);
      rd(4'd3, 4'd9, 4'd14);
      chk("range_no_side_effect", 32'(bus1.rd_data), 32'hFF3CA5);
      chk("range_err_clears", 32'(bus1.addr_err), 32'd0);

      for (int i = 0; i < 15; i++)
         wr(4'(i), 8'h80 | 8'(i));
      drive(1'b1, 1'b1, 4'd6, 8'h99, 1'b1, {4'd6, 4'd6, 4'd6});
      tick();
      idle();
      chk("clr_old_data", 32'(bus1.rd_data), 32'h868686);
      chk("clr_busy", 32'(bus1.busy), 32'd1);
      n   = 0;
      vld = 0;
      while (bus1.busy && n < 100) begin
         drive(1'b0, 1'b1, 4'd6, 8'h55, 1'b1, {4'd6, 4'd6, 4'd6});
         tick();
         if (bus1.rd_valid || bus0.rd_valid) vld++;
         n++;
      end
      idle();
      chk("clr_len", 32'(n), 32'd15);
      chk("clr_ignores_rd", 32'(vld), 32'd0);
      chk("clr_held_data", 32'(bus1.rd_data), 32'h868686);
      for (int i = 0; i < 15; i += 3) begin
         rd(4'(i), 4'(i + 1), 4'(i + 2));
         chk($sformatf("cleared_%0d", i), 32'(bus1.rd_data), 32'h0);
      end

      wr(4'd1, 8'h3E);
      drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b1, {4'd1, 4'd1, 4'd1});
      tick();
      idle();
      chk("clr2_read", 32'(bus1.rd_data), 32'h3E3E3E);
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("midsweep_rst_busy", 32'(bus1.busy), 32'd1);
      chk("midsweep_rst_data", 32'(bus1.rd_data), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      busyLen("resweep_len", 15);
      rd(4'd1, 4'd1, 4'd1);
      chk("resweep_data", 32'(bus1.rd_data), 32'h0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
